// File: rtl/bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter
//   N-digit BCD up/down counter with a programmable terminal value and a
//   multiplexed 7-segment scan driver. Everything runs on Clk; the count
//   and the display scan advance on prescaler ticks, not on derived clocks.
//
// Parameters
//   DIGITS     number of BCD digits (1..8)
//   COUNT_DIV  Clk cycles per count tick (>= 2)
//   SCAN_DIV   Clk cycles per display digit slot (>= 2)
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous, active-low reset
//   Enable     1 = count prescaler runs and counting is allowed
//   Up         1 = count up, 0 = count down (sampled on the tick cycle)
//   Wrap       1 = wrap at terminal, 0 = hold at terminal
//   Clear      synchronous clear of the count and the count prescaler
//   Limit      BCD terminal value; nibbles above 9 act as 9
//   Count      current BCD count
//   At_Limit   registered: count sits at the terminal for the direction
//   Rollover   one-cycle pulse on a wrap transition
//   Anode      active-low digit enables; bits >= DIGITS stay 1
//   Display    active-low segments {dp,g,f,e,d,c,b,a}; dp always 1
// ---------------------------------------------------------------------------
module bcd_scan_counter #(
   parameter int DIGITS    = 4,
   parameter int COUNT_DIV = 100000000,
   parameter int SCAN_DIV  = 100000
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Enable,
   input  logic                Up,
   input  logic                Wrap,
   input  logic                Clear,
   input  logic [4*DIGITS-1:0] Limit,
   output logic [4*DIGITS-1:0] Count,
   output logic                At_Limit,
   output logic                Rollover,
   output logic [7:0]          Anode,
   output logic [7:0]          Display
);

   localparam int CW  = 4 * DIGITS;
   localparam int CPW = $clog2(COUNT_DIV);
   localparam int SPW = $clog2(SCAN_DIV);
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CPW-1:0] CNT_LAST  = CPW'(COUNT_DIV - 1);
   localparam logic [SPW-1:0] SCAN_LAST = SPW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);

   logic [CPW-1:0] r_cnt_pre;
   logic [SPW-1:0] r_scan_pre;
   logic [IW-1:0]  r_idx;
   logic [CW-1:0]  r_count;
   logic           r_rollover;
   logic           r_at_limit;
   logic [7:0]     r_anode;
   logic [7:0]     r_display;

   logic [CW-1:0]  w_lim_sat;
   logic           w_tick;
   logic           w_up_done;
   logic           w_dn_done;
   logic [3:0]     w_digit;
   logic [7:0]     w_anode;

   // Ripple a +1 through the digits: a 9 becomes 0 and passes the carry on.
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Ripple a -1 through the digits: a 0 becomes 9 and passes the borrow on.
   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Terminal value with every out-of-range nibble forced to 9.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_lim_sat = Limit;
      for (int i = 0; i < DIGITS; i++) begin
         if (Limit[4*i +: 4] > 4'd9) w_lim_sat[4*i +: 4] = 4'd9;
      end
   end

   // Packed BCD compares in the same order as the numbers they encode.
   assign w_tick    = Enable && (r_cnt_pre == CNT_LAST);
   assign w_up_done = (r_count >= w_lim_sat);
   assign w_dn_done = (r_count == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block order.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_cnt_pre <= '0;
      end else if (Clear || w_tick) begin
         r_cnt_pre <= '0;
      end else if (Enable) begin
         r_cnt_pre <= r_cnt_pre + 1'b1;
      end
   end

   // Clear outranks the tick, so a coincident clear never pulses Rollover.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_count    <= '0;
         r_rollover <= 1'b0;
      end else begin
         r_rollover <= 1'b0;
         if (Clear) begin
            r_count <= '0;
         end else if (w_tick) begin
            if (Up) begin
               if (!w_up_done) begin
                  r_count <= bcd_inc(r_count);
               end else if (Wrap) begin
                  r_count    <= '0;
                  r_rollover <= 1'b1;
               end
            end else begin
               if (!w_dn_done) begin
                  r_count <= bcd_dec(r_count);
               end else if (Wrap) begin
                  r_count    <= w_lim_sat;
                  r_rollover <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) r_at_limit <= 1'b0;
      else        r_at_limit <= Up ? w_up_done : w_dn_done;
   end

   // Scan timing is free-running; Enable and Clear do not touch it.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_scan_pre <= '0;
         r_idx      <= '0;
      end else if (r_scan_pre == SCAN_LAST) begin
         r_scan_pre <= '0;
         r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_scan_pre <= r_scan_pre + 1'b1;
      end
   end

   always_comb begin
      w_digit = 4'd0;
      w_anode = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         if (i < DIGITS && r_idx == IW'(i)) begin
            w_anode[i] = 1'b0;
            w_digit    = r_count[4*i +: 4];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_anode   <= 8'hFF;
         r_display <= 8'hFF;
      end else begin
         r_anode   <= w_anode;
         r_display <= seg_decode(w_digit);
      end
   end

   assign Count    = r_count;
   assign At_Limit = r_at_limit;
   assign Rollover = r_rollover;
   assign Anode    = r_anode;
   assign Display  = r_display;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_counter
//   Directed scenarios followed by randomized stimulus. A decimal reference
//   model (count held as a plain integer, converted to BCD for comparison)
//   predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_bcd_scan_counter;

   localparam int DIGITS    = 4;
   localparam int COUNT_DIV = 4;
   localparam int SCAN_DIV  = 3;
   localparam int CW        = 4 * DIGITS;

   localparam logic [7:0] SEG_TABLE [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Enable;
   logic          Up;
   logic          Wrap;
   logic          Clear;
   logic [CW-1:0] Limit;
   logic [CW-1:0] Count;
   logic          At_Limit;
   logic          Rollover;
   logic [7:0]    Anode;
   logic [7:0]    Display;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int         m_count    = 0;
   int         m_pre      = 0;
   int         m_scan_pre = 0;
   int         m_idx      = 0;
   logic       m_at       = 1'b0;
   logic       m_roll     = 1'b0;
   logic [7:0] m_anode    = 8'hFF;
   logic [7:0] m_display  = 8'hFF;

   always #5 Clk = ~Clk;

   bcd_scan_counter #(
      .DIGITS    (DIGITS),
      .COUNT_DIV (COUNT_DIV),
      .SCAN_DIV  (SCAN_DIV)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Enable   (Enable),
      .Up       (Up),
      .Wrap     (Wrap),
      .Clear    (Clear),
      .Limit    (Limit),
      .Count    (Count),
      .At_Limit (At_Limit),
      .Rollover (Rollover),
      .Anode    (Anode),
      .Display  (Display)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_limit(input logic [CW-1:0] lim);
      int v;
      int p;
      v = 0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         int n;
         n = int'(lim[4*i +: 4]);
         if (n > 9) n = 9;
         v += n * p;
         p *= 10;
      end
      return v;
   endfunction

   function automatic logic [CW-1:0] to_bcd(input int v);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int digit_of(input int v, input int idx);
      for (int i = 0; i < idx; i++) v = v / 10;
      return v % 10;
   endfunction

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_step();
      int   lim;
      logic tick;
      lim = sat_limit(Limit);
      if (!Reset) begin
         m_count    = 0;
         m_pre      = 0;
         m_scan_pre = 0;
         m_idx      = 0;
         m_at       = 1'b0;
         m_roll     = 1'b0;
         m_anode    = 8'hFF;
         m_display  = 8'hFF;
      end else begin
         m_at             = Up ? (m_count >= lim) : (m_count == 0);
         m_anode          = 8'hFF;
         m_anode[m_idx]   = 1'b0;
         m_display        = SEG_TABLE[digit_of(m_count, m_idx)];
         if (m_scan_pre == SCAN_DIV - 1) begin
            m_scan_pre = 0;
            m_idx      = (m_idx + 1) % DIGITS;
         end else begin
            m_scan_pre++;
         end
         tick   = Enable && (m_pre == COUNT_DIV - 1);
         m_roll = 1'b0;
         if (Clear) begin
            m_count = 0;
            m_pre   = 0;
         end else begin
            if (Enable) m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
               if (Up) begin
                  if (m_count < lim) m_count++;
                  else if (Wrap) begin
                     m_count = 0;
                     m_roll  = 1'b1;
                  end
               end else begin
                  if (m_count > 0) m_count--;
                  else if (Wrap) begin
                     m_count = lim;
                     m_roll  = 1'b1;
                  end
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge Clk);
      model_step();
      #1;
      check("count",    32'(Count),    32'(to_bcd(m_count)));
      check("at_limit", 32'(At_Limit), 32'(m_at));
      check("rollover", 32'(Rollover), 32'(m_roll));
      check("anode",    32'(Anode),    32'(m_anode));
      check("display",  32'(Display),  32'(m_display));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      Reset  = 1'b0;
      Enable = 1'b1;
      Up     = 1'b1;
      Wrap   = 1'b1;
      Clear  = 1'b0;
      Limit  = 16'h0059;

      // Reset held with Enable high
      run(3);
      check("rst_count",    32'(Count),    32'h0);
      check("rst_anode",    32'(Anode),    32'hFF);
      check("rst_display",  32'(Display),  32'hFF);
      check("rst_rollover", 32'(Rollover), 32'h0);
      Reset = 1'b1;
      step();
      check("first_anode",   32'(Anode),   32'hFE);
      check("first_display", 32'(Display), 32'hC0);

      // Up count to 59 and wrap to 00
      run(250);

      // Stop mode at 12, then turn around
      Wrap  = 1'b0;
      Limit = 16'h0012;
      run(60);
      check("stop_hold",  32'(Count),    32'h0012);
      check("stop_atlim", 32'(At_Limit), 32'h1);
      Up = 1'b0;
      run(4);
      check("stop_down", 32'(Count), 32'h0011);

      // Down wrap from 00 to the saturated limit
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      Limit = 16'h003F;
      Wrap  = 1'b1;
      run(4);
      check("dn_wrap",      32'(Count),    32'h0039);
      check("dn_wrap_roll", 32'(Rollover), 32'h1);
      run(4);
      check("dn_next",      32'(Count),    32'h0038);
      check("dn_next_roll", 32'(Rollover), 32'h0);

      // Limit zero, counting up with wrap: every tick rolls over
      Up    = 1'b1;
      Limit = 16'h0000;
      run(16);

      // Count up to 1234 and watch the scan across all four digits
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      Limit = 16'h1234;
      Wrap  = 1'b0;
      run(1234 * COUNT_DIV + 40);
      check("scan_count", 32'(Count), 32'h1234);
      run(24);

      // Freeze, then clear on a tick cycle
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      run(10);
      Enable = 1'b0;
      run(20);
      Enable = 1'b1;
      for (int k = 0; k < COUNT_DIV && m_pre != COUNT_DIV - 1; k++) step();
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      check("clr_count", 32'(Count),    32'h0);
      check("clr_roll",  32'(Rollover), 32'h0);
      run(COUNT_DIV - 1);
      check("clr_wait", 32'(Count), 32'h0);
      step();
      check("clr_tick", 32'(Count), 32'h0001);

      // Reset in the middle of counting and scanning
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      run(5);

      // Randomized stimulus
      for (int c = 0; c < 4000; c++) begin
         Reset  = ($urandom_range(0, 399) != 0);
         Clear  = ($urandom_range(0, 79) == 0);
         Enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 39) == 0) begin
            Up    = 1'($urandom_range(0, 1));
            Wrap  = 1'($urandom_range(0, 1));
            Limit = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                : 16'($urandom_range(0, 16'h00FF));
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised N-digit BCD up/down counter with a programmable terminal value and a built-in multiplexed 7-segment scan driver. It replaces the fixed two-digit ones/tens counter chain, its derived slow clocks and its stop comparator with a single-clock, tick-enable design. It sits between the board clock/reset and the Nexys-style 8-anode display, and also exports the count for other logic.

## Interface
- DIGITS, 4, number of BCD digits, 1..8
- COUNT_DIV, 100000000, Clk cycles per count tick, ≥2
- SCAN_DIV, 100000, Clk cycles per display digit slot, ≥2
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- Enable  in  1  1 = prescaler runs and counting allowed; 0 = freeze prescaler and count
- Up  in  1  1 = count up, 0 = count down; sampled on the tick cycle
- Wrap  in  1  1 = wrap at terminal; 0 = stop (hold) at terminal
- Clear  in  1  synchronous clear of count and count prescaler
- Limit  in  4*DIGITS  BCD terminal value; any nibble >9 is treated as 9
- Count  out  4*DIGITS  current BCD count
- At_Limit  out  1  registered; count equals terminal for current direction
- Rollover  out  1  one-cycle pulse on a wrap transition
- Anode  out  8  active-low digit enables; bits ≥ DIGITS held 1
- Display  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1

## Operation
- Count prescaler: 0..COUNT_DIV-1, increments while Enable=1; tick = (prescaler == COUNT_DIV-1 && Enable); wraps to 0 on tick. Enable=0 holds value.
- Priority per cycle: Reset > Clear > tick > hold.
- Terminal: up → Limit (saturated nibbles); down → 0.
- On tick, up: count < terminal → BCD increment with per-digit carry (9→0, carry next). count ≥ terminal (Limit lowered below count) → Wrap=1: Count=0, Rollover=1; Wrap=0: hold.
- On tick, down: count > 0 → BCD decrement with per-digit borrow (0→9). count == 0 → Wrap=1: Count=terminal-up value (saturated Limit), Rollover=1; Wrap=0: hold.
- Limit = 0, up, Wrap=1: every tick yields Count=0 with Rollover pulse.
- At_Limit registered each cycle: Up ? (Count ≥ sat(Limit)) : (Count == 0), evaluated on the registered Count.
- Scan: prescaler 0..SCAN_DIV-1 always runs (independent of Enable/Clear); at SCAN_DIV-1, digit index advances 0→1→…→DIGITS-1→0. DIGITS=1: index stays 0.
- Anode: bit[index]=0, all others 1. Display: decode of Count nibble[index]: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90 (hex).
- Compares use BCD numeric order (equals binary order of the packed nibbles).

## Timing
- Reset (Reset=0 at edge): Count=0, both prescalers=0, index=0, At_Limit=0, Rollover=0, Anode=8'hFF, Display=8'hFF.
- Count updates on the edge where tick is true; Rollover high exactly that next cycle only.
- At_Limit lags Count by one cycle.
- Anode/Display registered: reflect index and Count from the previous cycle (1-cycle latency); first valid digit-0 drive on the 1st cycle after Reset released (Anode=8'hFE, Display=8'hC0).
- Clear coincident with tick: Count=0, no Rollover; prescaler restarts at 0.
- Reset mid-count or mid-scan: all state returns to reset values on that edge regardless of Enable/Clear.
- Up/Wrap/Limit changes take effect on the next tick; no glitch on Count otherwise.

## Test plan
- Reset: hold Reset=0 3 cycles with Enable=1 → Count=0, Anode=FF, Display=FF, Rollover=0; release → next cycle Anode=FE, Display=C0.
- Up count, DIGITS=2, COUNT_DIV=4, Limit=8'h59, Wrap=1: Count steps every 4 cycles 00…09→10…59→00; Rollover one cycle at 59→00; At_Limit=1 one cycle after 59 reached.
- Stop mode: Wrap=0, Limit=8'h12, Up=1 → Count holds 12 indefinitely, At_Limit=1, no Rollover; switch Up=0 → next tick 11, At_Limit=0.
- Down wrap: Count=00, Up=0, Wrap=1, Limit=8'h3F (nibble saturated) → next tick Count=39, Rollover pulse; then 38.
- Scan: DIGITS=4, SCAN_DIV=3, Count=16'h1234 → Anode cycles FE,FD,FB,F7 every 3 cycles with Display 99,B0,A4,F9; bits 7:4 always 1.
- Clear/Enable: Enable=0 for 20 cycles → Count and count prescaler frozen; Clear on a tick cycle → Count=0, no Rollover, next tick 4 cycles later (COUNT_DIV=4).
